// File: rtl/sdram_segment_responder.sv
// Avalon-MM style SDRAM stand-in for the TCAM controller: on-chip segment RAM cleared after reset,
// fixed-latency in-order reads, bounded outstanding reads and periodic refresh stalls.
module sdram_segment_responder #(
  parameter int DATA_BITS      = 10,
  parameter int FRAGMENTS      = 5,
  parameter int FRAG_BITS      = 3,
  parameter int IDWID          = 2,
  parameter int MASKWID        = 5,
  parameter int RD_LATENCY     = 3,
  parameter int MAX_PEND       = 2,
  parameter int REFRESH_PERIOD = 64,
  parameter int REFRESH_CYCLES = 4,
  localparam int ADDR_WID      = FRAG_BITS + DATA_BITS / FRAGMENTS,
  localparam int SEGWID        = 2 + 2 * IDWID + MASKWID + DATA_BITS
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                SDRAM_READ,
  input  logic                SDRAM_WRITE,
  input  logic [ADDR_WID-1:0] SDRAM_ADDRESS,
  input  logic [SEGWID-1:0]   SDRAM_WRITEDATA,
  output logic [SEGWID-1:0]   SDRAM_READDATA,
  output logic                SDRAM_WAITREQUEST,
  output logic                SDRAM_READDATAVALID,
  output logic                INIT_DONE,
  output logic                PROTO_ERR
);

  localparam int DEPTH   = 2 ** ADDR_WID;
  localparam int PEND_W  = $clog2(MAX_PEND + 1);
  localparam int REF_W   = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam int STALL_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_REFRESH} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [SEGWID-1:0]   mem [DEPTH];
  logic [ADDR_WID-1:0] clr_ptr;
  logic [PEND_W-1:0]   pend;
  logic [REF_W-1:0]    ref_cnt;
  logic [STALL_W-1:0]  stall_cnt;
  logic [RD_LATENCY-1:0] pipe_vld;
  logic [SEGWID-1:0]   pipe_data [RD_LATENCY];
  logic                init_done;
  logic                proto_err;
  logic                wait_req;
  logic                acc;
  logic                wr_acc;
  logic                rd_acc;
  logic                ret_vld;
  logic                ref_hit;
  logic                clr_end;
  logic                stall_end;

  // Stall decision uses registered state only, so it never depends on the incoming command.
  assign wait_req  = (state != ST_RUN) || (pend == PEND_W'(MAX_PEND));
  assign acc       = (SDRAM_READ || SDRAM_WRITE) && !wait_req;
  assign wr_acc    = acc && SDRAM_WRITE;
  assign rd_acc    = acc && !SDRAM_WRITE;
  assign ret_vld   = pipe_vld[RD_LATENCY-1];
  assign ref_hit   = (REFRESH_PERIOD != 0) && (ref_cnt == REF_W'(REFRESH_PERIOD - 1));
  assign clr_end   = (clr_ptr == ADDR_WID'(DEPTH - 1));
  assign stall_end = (stall_cnt == STALL_W'(REFRESH_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:    if (clr_end) state_nxt = ST_RUN;
      ST_RUN:     if (ref_hit) state_nxt = ST_REFRESH;
      ST_REFRESH: if (stall_end) state_nxt = ST_RUN;
      default:    state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_INIT;
      clr_ptr   <= '0;
      ref_cnt   <= '0;
      stall_cnt <= '0;
      pend      <= '0;
      pipe_vld  <= '0;
      init_done <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) clr_ptr <= clr_ptr + ADDR_WID'(1);
      if (state == ST_RUN) ref_cnt <= ref_hit ? '0 : ref_cnt + REF_W'(1);
      if (state == ST_REFRESH) stall_cnt <= stall_end ? '0 : stall_cnt + STALL_W'(1);
      if (state_nxt == ST_RUN) init_done <= 1'b1;
      if (acc && SDRAM_READ && SDRAM_WRITE) proto_err <= 1'b1;
      if (rd_acc && !ret_vld) pend <= pend + PEND_W'(1);
      else if (!rd_acc && ret_vld) pend <= pend - PEND_W'(1);
      pipe_vld[0] <= rd_acc;
      for (int i = 1; i < RD_LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  // Read data is captured at accept time, so later writes to the same address cannot leak in.
  always_ff @(posedge CLK) begin
    pipe_data[0] <= mem[SDRAM_ADDRESS];
    for (int i = 1; i < RD_LATENCY; i++) pipe_data[i] <= pipe_data[i-1];
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (state == ST_INIT) mem[clr_ptr] <= '0;
      else if (wr_acc) mem[SDRAM_ADDRESS] <= SDRAM_WRITEDATA;
    end
  end

  assign SDRAM_WAITREQUEST   = wait_req;
  assign SDRAM_READDATAVALID = ret_vld;
  assign SDRAM_READDATA      = ret_vld ? pipe_data[RD_LATENCY-1] : '0;
  assign INIT_DONE           = init_done;
  assign PROTO_ERR           = proto_err;

endmodule

// File: tb/tb_sdram_segment_responder.sv
// Bench for sdram_segment_responder: directed phases with random data, every cycle compared
// against a transaction-level model (cycle schedule arithmetic, return queue, memory array).
module tb_sdram_segment_responder;

  localparam int ADDR_WID       = 5;
  localparam int SEGWID         = 21;
  localparam int DEPTH          = 32;
  localparam int RD_LATENCY     = 3;
  localparam int MAX_PEND       = 2;
  localparam int REFRESH_PERIOD = 64;
  localparam int REFRESH_CYCLES = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                sdram_read = 1'b0;
  logic                sdram_write = 1'b0;
  logic [ADDR_WID-1:0] sdram_address = '0;
  logic [SEGWID-1:0]   sdram_writedata = '0;
  logic [SEGWID-1:0]   sdram_readdata;
  logic                sdram_waitrequest;
  logic                sdram_readdatavalid;
  logic                init_done;
  logic                proto_err;

  typedef struct {
    int                due;
    logic [SEGWID-1:0] data;
  } ret_t;

  ret_t              ret_q[$];
  logic [SEGWID-1:0] ref_mem [DEPTH];
  bit                ref_proto;
  int                cyc;
  int                n_checks = 0;
  int                n_fails = 0;
  bit                acc;

  sdram_segment_responder dut (
    .CLK                 (clk),
    .RESET               (reset),
    .SDRAM_READ          (sdram_read),
    .SDRAM_WRITE         (sdram_write),
    .SDRAM_ADDRESS       (sdram_address),
    .SDRAM_WRITEDATA     (sdram_writedata),
    .SDRAM_READDATA      (sdram_readdata),
    .SDRAM_WAITREQUEST   (sdram_waitrequest),
    .SDRAM_READDATAVALID (sdram_readdatavalid),
    .INIT_DONE           (init_done),
    .PROTO_ERR           (proto_err)
  );

  always #5 clk = ~clk;

  // Cycle 0 is the first cycle with reset low; clearing takes DEPTH cycles, then RUN/REFRESH repeat.
  function automatic bit refStall(int c);
    int k;
    if (c < DEPTH) return 1'b1;
    k = (c - DEPTH) % (REFRESH_PERIOD + REFRESH_CYCLES);
    return k >= REFRESH_PERIOD;
  endfunction

  function automatic bit refReady();
    return !refStall(cyc) && (ret_q.size() < MAX_PEND);
  endfunction

  task automatic checkOutput(input string tag, input logic [SEGWID-1:0] observed,
                             input logic [SEGWID-1:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fails++;
      $error("[TB] FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit w, input logic [ADDR_WID-1:0] a,
                               input logic [SEGWID-1:0] d, output bit accepted);
    bit exp_wait;
    bit exp_valid;
    logic [SEGWID-1:0] exp_data;
    ret_t item;
    @(negedge clk);
    reset = 1'b0;
    sdram_read = r;
    sdram_write = w;
    sdram_address = a;
    sdram_writedata = d;
    #1;
    exp_wait  = refStall(cyc) || (ret_q.size() == MAX_PEND);
    exp_valid = (ret_q.size() > 0) && (ret_q[0].due == cyc);
    exp_data  = exp_valid ? ret_q[0].data : '0;
    checkOutput("waitrequest", SEGWID'(sdram_waitrequest), SEGWID'(exp_wait));
    checkOutput("readdatavalid", SEGWID'(sdram_readdatavalid), SEGWID'(exp_valid));
    checkOutput("readdata", sdram_readdata, exp_data);
    checkOutput("init_done", SEGWID'(init_done), SEGWID'(cyc >= DEPTH));
    checkOutput("proto_err", SEGWID'(proto_err), SEGWID'(ref_proto));
    if (exp_valid) void'(ret_q.pop_front());
    accepted = (r || w) && !exp_wait;
    if (accepted && w) begin
      ref_mem[a] = d;
      if (r) ref_proto = 1'b1;
    end else if (accepted) begin
      item.due  = cyc + RD_LATENCY;
      item.data = ref_mem[a];
      ret_q.push_back(item);
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    sdram_read = 1'b0;
    sdram_write = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_waitrequest", SEGWID'(sdram_waitrequest), SEGWID'(1));
    checkOutput("rst_readdatavalid", SEGWID'(sdram_readdatavalid), SEGWID'(0));
    checkOutput("rst_readdata", sdram_readdata, SEGWID'(0));
    checkOutput("rst_init_done", SEGWID'(init_done), SEGWID'(0));
    checkOutput("rst_proto_err", SEGWID'(proto_err), SEGWID'(0));
    ret_q.delete();
    ref_proto = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    cyc = 0;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, ADDR_WID'($urandom), SEGWID'($urandom), a);
  endtask

  task automatic waitReady();
    int guard = 0;
    while (!refReady() && guard < 200) begin
      idle(1);
      guard++;
    end
    if (!refReady()) begin
      n_fails++;
      $error("[TB] FAIL ready_timeout cyc=%0d observed=stalled expected=ready", cyc);
    end
  endtask

  task automatic issue(input bit r, input bit w, input logic [ADDR_WID-1:0] a,
                       input logic [SEGWID-1:0] d);
    bit a_ok;
    waitReady();
    applyStimulus(r, w, a, d, a_ok);
  endtask

  initial begin
    int idx;
    int guard;
    applyReset();

    // Commands during clearing (including READ+WRITE together) must be ignored without a flag.
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'($urandom), 1'($urandom), ADDR_WID'($urandom), SEGWID'($urandom), acc);
    issue(1'b1, 1'b0, 5'h05, '0);
    idle(4);

    issue(1'b0, 1'b1, 5'h0A, 21'h1ABCD);
    applyStimulus(1'b1, 1'b0, 5'h0A, SEGWID'($urandom), acc);
    idle(5);

    for (int i = 1; i <= 5; i++) issue(1'b0, 1'b1, ADDR_WID'(i), SEGWID'(21'h10 + i));
    waitReady();
    idx = 1;
    guard = 0;
    while (idx <= 5 && guard < 60) begin
      applyStimulus(1'b1, 1'b0, ADDR_WID'(idx), SEGWID'($urandom), acc);
      if (acc) idx++;
      guard++;
    end
    idle(5);

    for (int i = 0; i < 200; i++)
      applyStimulus(1'b1, 1'b0, ADDR_WID'($urandom), SEGWID'($urandom), acc);
    idle(5);

    issue(1'b1, 1'b1, 5'h03, 21'h00055);
    idle(4);
    issue(1'b1, 1'b0, 5'h03, '0);
    idle(5);

    for (int i = 0; i < 300; i++) begin
      int kind = $urandom_range(0, 9);
      applyStimulus(kind inside {[0:4], 9}, kind inside {[5:7], 9},
                    ADDR_WID'($urandom), SEGWID'($urandom), acc);
    end
    idle(5);

    issue(1'b0, 1'b1, 5'h0A, 21'h1ABCD);
    issue(1'b0, 1'b1, 5'h0B, 21'h0F0F0);
    idle(4);
    issue(1'b1, 1'b0, 5'h0A, '0);
    applyStimulus(1'b1, 1'b0, 5'h0B, '0, acc);
    applyReset();
    idle(DEPTH + 4);
    issue(1'b1, 1'b0, 5'h0A, '0);
    issue(1'b1, 1'b0, 5'h0B, '0);
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
